read_return_unit: RTL and testbench

READ_RETURN_UNIT -- requirements
Module: read_return_unit

---
 rtl/rd_pkg.sv | 22 ++
 rtl/onehot_mux.sv | 28 ++
 rtl/read_return_unit.sv | 152 +++++++++++++++
 tb/tb_read_return_unit.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rd_pkg.sv
// Shared definitions for the read return unit.
//   - Default sizing: DW (data width), NREG (register-file words), TIMEOUT
//     (RAM wait budget in cycles), RAM_BASE (first RAM address).
//   - AW / CNT_W: address width and wait-counter width.
//   - state_e: read-return FSM states.
package rd_pkg;

  localparam int unsigned DW       = 8;
  localparam int unsigned NREG     = 12;
  localparam int unsigned TIMEOUT  = 16;
  localparam int unsigned RAM_BASE = 12;
  localparam int unsigned AW       = 12;
  localparam int unsigned CNT_W    = 5;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REG      = 2'd1,
    RAM_WAIT = 2'd2,
    RESP     = 2'd3
  } state_e;

endpackage : rd_pkg

// File: rtl/onehot_mux.sv
// Combinational register-word selector.
// Ports:
//   SEL     in  NREG     select vector, normally one-hot
//   REG_BUS in  NREG*DW  packed register words, word i at [i*DW +: DW]
//   WORD    out DW       OR of every selected word (0 when SEL is 0)
module onehot_mux
  import rd_pkg::*;
#(
  parameter int unsigned DW   = rd_pkg::DW,
  parameter int unsigned NREG = rd_pkg::NREG
) (
  input  logic [NREG-1:0]    SEL,
  input  logic [NREG*DW-1:0] REG_BUS,
  output logic [DW-1:0]      WORD
);

  // AND-OR mux: a one-hot SEL gives a clean select, and multiple set bits
  // merge their words, which is the defined behaviour for a bad decode.
  always_comb begin
    WORD = '0;
    for (int unsigned i = 0; i < NREG; i++) begin
      if (SEL[i]) begin
        WORD = WORD | REG_BUS[i*DW +: DW];
      end
    end
  end

endmodule : onehot_mux

// File: rtl/read_return_unit.sv
// Read return unit: accepts a CPU read request and returns data either from
// the register file (fixed two-cycle latency) or from an external RAM with
// a bounded acknowledge wait.
// Ports:
//   CLK, RST_N  clock, asynchronous active-low reset
//   REQ         read request strobe (accepted only when not BUSY)
//   ADD         read address
//   SEL         one-hot register select from the address decode
//   RAM_S       request targets the RAM region (ADD >= NREG)
//   REG_BUS     packed register-file contents
//   RAM_RD      RAM read request, held while waiting for RAM_ACK
//   RAM_ADDR    RAM word address (ADD - NREG)
//   RAM_ACK     RAM data valid strobe, only honoured while waiting
//   RAM_Q       RAM read data
//   BUSY        unit is processing a request
//   DOUT        returned data, held until the next capture
//   DVALID      one-cycle strobe marking DOUT/ERR valid
//   ERR         error flag (RAM timeout, or bad select when checked)
// Build option: define READ_ONEHOT_CHECK_EN to turn a register select that
// is not exactly one-hot into an error response with DOUT=0.
module read_return_unit
  import rd_pkg::*;
#(
  parameter int unsigned DW      = rd_pkg::DW,
  parameter int unsigned NREG    = rd_pkg::NREG,
  parameter int unsigned TIMEOUT = rd_pkg::TIMEOUT
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               REQ,
  input  logic [11:0]        ADD,
  input  logic [NREG-1:0]    SEL,
  input  logic               RAM_S,
  input  logic [NREG*DW-1:0] REG_BUS,
  output logic               RAM_RD,
  output logic [11:0]        RAM_ADDR,
  input  logic               RAM_ACK,
  input  logic [DW-1:0]      RAM_Q,
  output logic               BUSY,
  output logic [DW-1:0]      DOUT,
  output logic               DVALID,
  output logic               ERR
);

  localparam logic [11:0]      RAM_OFFSET = 12'(NREG);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [NREG-1:0]  sel_q, sel_d;
  logic [11:0]      ram_addr_q, ram_addr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DW-1:0]    dout_q, dout_d;
  logic             err_q, err_d;
  logic [DW-1:0]    reg_word;

  onehot_mux #(
    .DW   (DW),
    .NREG (NREG)
  ) u_mux (
    .SEL     (sel_q),
    .REG_BUS (REG_BUS),
    .WORD    (reg_word)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= IDLE;
      sel_q      <= '0;
      ram_addr_q <= '0;
      cnt_q      <= '0;
      dout_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      ram_addr_q <= ram_addr_d;
      cnt_q      <= cnt_d;
      dout_q     <= dout_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    ram_addr_d = ram_addr_q;
    cnt_d      = cnt_q;
    dout_d     = dout_q;
    err_d      = err_q;

    unique case (state_q)
      IDLE: begin
        if (REQ) begin
          sel_d = SEL;
          // The region flag only steers the next state, so the state itself
          // is its latched copy; the RAM address is pre-offset here.
          if (RAM_S) begin
            ram_addr_d = ADD - RAM_OFFSET;
            cnt_d      = '0;
            state_d    = RAM_WAIT;
          end else begin
            state_d = REG;
          end
        end
      end

      REG: begin
        dout_d  = reg_word;
        err_d   = 1'b0;
`ifdef READ_ONEHOT_CHECK_EN
        if ((sel_q == '0) || ((sel_q & (sel_q - 1'b1)) != '0)) begin
          dout_d = '0;
          err_d  = 1'b1;
        end
`endif
        state_d = RESP;
      end

      RAM_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        // Ack is tested first so a late ack on the timeout cycle still wins.
        if (RAM_ACK) begin
          dout_d  = RAM_Q;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (cnt_q == CNT_LAST) begin
          dout_d  = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Status outputs decode straight from the state register, so an async
  // reset clears them in the same instant it clears the state.
  assign RAM_RD   = (state_q == RAM_WAIT);
  assign BUSY     = (state_q != IDLE);
  assign DVALID   = (state_q == RESP);
  assign RAM_ADDR = ram_addr_q;
  assign DOUT     = dout_q;
  assign ERR      = err_q;

endmodule : read_return_unit

// File: tb/tb_read_return_unit.sv
module tb_read_return_unit;

  localparam int unsigned DW   = 8;
  localparam int unsigned NREG = 12;

  logic               CLK;
  logic               RST_N;
  logic               REQ;
  logic [11:0]        ADD;
  logic [NREG-1:0]    SEL;
  logic               RAM_S;
  logic [NREG*DW-1:0] REG_BUS;
  logic               RAM_RD;
  logic [11:0]        RAM_ADDR;
  logic               RAM_ACK;
  logic [DW-1:0]      RAM_Q;
  logic               BUSY;
  logic [DW-1:0]      DOUT;
  logic               DVALID;
  logic               ERR;

  read_return_unit #(
    .DW      (DW),
    .NREG    (NREG),
    .TIMEOUT (16)
  ) dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .REQ      (REQ),
    .ADD      (ADD),
    .SEL      (SEL),
    .RAM_S    (RAM_S),
    .REG_BUS  (REG_BUS),
    .RAM_RD   (RAM_RD),
    .RAM_ADDR (RAM_ADDR),
    .RAM_ACK  (RAM_ACK),
    .RAM_Q    (RAM_Q),
    .BUSY     (BUSY),
    .DOUT     (DOUT),
    .DVALID   (DVALID),
    .ERR      (ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [DW-1:0] dout;
    logic          err;
  } exp_t;

  typedef struct {
    logic [11:0]     add;
    logic [NREG-1:0] sel;
    logic [DW-1:0]   dout;
    logic            err;
  } vec_t;

  exp_t sb[$];
  vec_t vt[8];
  int   n_checks;
  int   n_fail;

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called in a DVALID cycle: compares DOUT/ERR against the oldest expectation.
  task automatic pop_check(input string tag);
    exp_t e;
    check_val({tag, "_dvalid"}, 32'(DVALID), 32'd1);
    n_checks++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL %s_sb: response with empty scoreboard, DOUT=0x%0h", tag, DOUT);
    end else begin
      e = sb.pop_front();
      check_val({tag, "_dout"}, 32'(DOUT), 32'(e.dout));
      check_val({tag, "_err"}, 32'(ERR), 32'(e.err));
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_ram_rd"}, 32'(RAM_RD), 32'd0);
    check_val({tag, "_ram_addr"}, 32'(RAM_ADDR), 32'd0);
    check_val({tag, "_busy"}, 32'(BUSY), 32'd0);
    check_val({tag, "_dout"}, 32'(DOUT), 32'd0);
    check_val({tag, "_dvalid"}, 32'(DVALID), 32'd0);
    check_val({tag, "_err"}, 32'(ERR), 32'd0);
  endtask

  // Drives a RAM request at the current negedge; returns just after accept.
  task automatic issue_ram(input logic [11:0] add);
    REQ   = 1'b1;
    ADD   = add;
    SEL   = '0;
    RAM_S = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    REQ   = 1'b0;
    RAM_S = 1'b0;
  endtask

  initial begin
    int ram_cycles;
    bit seen;

    n_checks = 0;
    n_fail   = 0;
    RST_N    = 1'b1;
    REQ      = 1'b0;
    ADD      = '0;
    SEL      = '0;
    RAM_S    = 1'b0;
    RAM_ACK  = 1'b0;
    RAM_Q    = '0;
    for (int i = 0; i < int'(NREG); i++) REG_BUS[i*DW +: DW] = 8'hA0 + 8'(i);

    // Register words are 0xA0 + index; multi-select rows are the OR of words.
    vt[0] = '{12'h005, 12'h020, 8'hA5, 1'b0};
    vt[1] = '{12'h000, 12'h001, 8'hA0, 1'b0};
    vt[2] = '{12'h00B, 12'h800, 8'hAB, 1'b0};
    vt[3] = '{12'h003, 12'h008, 8'hA3, 1'b0};
`ifdef READ_ONEHOT_CHECK_EN
    vt[4] = '{12'h000, 12'h000, 8'h00, 1'b1};
    vt[5] = '{12'h004, 12'h030, 8'h00, 1'b1};
    vt[6] = '{12'h001, 12'h006, 8'h00, 1'b1};
    vt[7] = '{12'h000, 12'h003, 8'h00, 1'b1};
`else
    vt[4] = '{12'h000, 12'h000, 8'h00, 1'b0};
    vt[5] = '{12'h004, 12'h030, 8'hA5, 1'b0};
    vt[6] = '{12'h001, 12'h006, 8'hA3, 1'b0};
    vt[7] = '{12'h000, 12'h003, 8'hA1, 1'b0};
`endif

    // Reset state
    #2 RST_N = 1'b0;
    #3 check_all_zero("reset");
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    check_all_zero("post_reset");

    // Register reads: accept at edge n, REG at n+1, DVALID at n+2
    for (int v = 0; v < 8; v++) begin
      REQ   = 1'b1;
      ADD   = vt[v].add;
      SEL   = vt[v].sel;
      RAM_S = 1'b0;
      sb.push_back('{vt[v].dout, vt[v].err});
      @(posedge CLK);
      @(negedge CLK);
      check_val("reg_busy_c1", 32'(BUSY), 32'd1);
      check_val("reg_dvalid_c1", 32'(DVALID), 32'd0);
      // A new request while busy must be ignored and must not disturb SEL latch
      SEL = 12'h001;
      ADD = 12'h000;
      @(posedge CLK);
      @(negedge CLK);
      check_val("reg_busy_c2", 32'(BUSY), 32'd1);
      pop_check("reg_read");
      REQ = 1'b0;
      SEL = '0;
      @(posedge CLK);
      @(negedge CLK);
      check_val("reg_idle_busy", 32'(BUSY), 32'd0);
      check_val("reg_idle_dvalid", 32'(DVALID), 32'd0);
      check_val("reg_dout_hold", 32'(DOUT), 32'(vt[v].dout));
    end

    // RAM read, ack after three waiting cycles
    sb.push_back('{8'h3C, 1'b0});
    issue_ram(12'h010);
    check_val("ram_addr", 32'(RAM_ADDR), 32'h004);
    for (int c = 0; c < 3; c++) begin
      if (c > 0) @(negedge CLK);
      check_val("ram_rd_wait", 32'(RAM_RD), 32'd1);
      check_val("ram_dvalid_wait", 32'(DVALID), 32'd0);
      @(posedge CLK);
    end
    @(negedge CLK);
    RAM_ACK = 1'b1;
    RAM_Q   = 8'h3C;
    @(posedge CLK);
    @(negedge CLK);
    RAM_ACK = 1'b0;
    RAM_Q   = 8'hFF;
    pop_check("ram_ack");
    check_val("ram_rd_drop", 32'(RAM_RD), 32'd0);
    @(posedge CLK);
    @(negedge CLK);
    check_val("ram_ack_single_strobe", 32'(DVALID), 32'd0);

    // Stray ack while idle: nothing happens
    RAM_ACK = 1'b1;
    RAM_Q   = 8'h55;
    @(posedge CLK);
    @(negedge CLK);
    RAM_ACK = 1'b0;
    check_val("idle_ack_dvalid", 32'(DVALID), 32'd0);
    check_val("idle_ack_dout", 32'(DOUT), 32'h3C);

    // RAM timeout: 16 cycles in wait, then error response
    sb.push_back('{8'h00, 1'b1});
    issue_ram(12'h0FF);
    check_val("to_ram_addr", 32'(RAM_ADDR), 32'h0F3);
    ram_cycles = 0;
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      if (c > 0) @(negedge CLK);
      if (DVALID) seen = 1'b1;
      else if (RAM_RD) ram_cycles++;
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout_wait: no DVALID within 40 cycles");
    end else begin
      check_val("timeout_cycles", 32'(ram_cycles), 32'd16);
      check_val("timeout_ram_rd", 32'(RAM_RD), 32'd0);
      pop_check("timeout");
    end
    @(posedge CLK);
    @(negedge CLK);
    check_val("timeout_idle", 32'(BUSY), 32'd0);

    // Ack on the timeout cycle wins; a request while busy is dropped
    sb.push_back('{8'h77, 1'b0});
    issue_ram(12'h020);
    repeat (15) @(posedge CLK);
    @(negedge CLK);
    check_val("coinc_still_wait", 32'(RAM_RD), 32'd1);
    check_val("coinc_no_early", 32'(DVALID), 32'd0);
    RAM_ACK = 1'b1;
    RAM_Q   = 8'h77;
    REQ     = 1'b1;
    ADD     = 12'h005;
    SEL     = 12'h020;
    @(posedge CLK);
    @(negedge CLK);
    RAM_ACK = 1'b0;
    pop_check("coinc");
    REQ = 1'b0;
    SEL = '0;
    @(posedge CLK);
    @(negedge CLK);
    check_val("busy_req_dropped_busy", 32'(BUSY), 32'd0);
    @(posedge CLK);
    @(negedge CLK);
    check_val("busy_req_dropped_dvalid", 32'(DVALID), 32'd0);

    // Reset mid-wait abandons the read; a later ack is ignored
    issue_ram(12'h018);
    repeat (4) @(posedge CLK);
    @(negedge CLK);
    RST_N = 1'b0;
    #1 check_all_zero("mid_reset");
    @(negedge CLK);
    RST_N   = 1'b1;
    RAM_ACK = 1'b1;
    RAM_Q   = 8'h99;
    @(posedge CLK);
    @(negedge CLK);
    RAM_ACK = 1'b0;
    for (int c = 0; c < 4; c++) begin
      check_all_zero("stale_ack");
      @(negedge CLK);
    end

    check_val("sb_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule : tb_read_return_unit
